// File: rtl/sdf_bf_stage_if.sv
// ----------------------------------------------------------------------------
// sdf_bf_stage_if
// Sample-stream bundle for the radix-2 SDF butterfly stage.
//   i_vld        : input sample valid
//   i_re, i_im   : signed input sample, DATA_W bits per component
//   o_vld        : output sample valid
//   o_re, o_im   : signed result, DATA_W+1 bits per component
//   o_sum        : 1 = result is a sum (a+b), 0 = result is a difference (a-b)
// master : the side that produces samples and consumes results
// slave  : the butterfly stage itself
// ----------------------------------------------------------------------------
interface sdf_bf_stage_if #(
    parameter int DATA_W = 16
);
    logic                     i_vld;
    logic signed [DATA_W-1:0] i_re;
    logic signed [DATA_W-1:0] i_im;
    logic                     o_vld;
    logic signed [DATA_W:0]   o_re;
    logic signed [DATA_W:0]   o_im;
    logic                     o_sum;

    modport master (
        output i_vld, i_re, i_im,
        input  o_vld, o_re, o_im, o_sum
    );

    modport slave (
        input  i_vld, i_re, i_im,
        output o_vld, o_re, o_im, o_sum
    );
endinterface

// File: rtl/sdf_bf_stage.sv
// ----------------------------------------------------------------------------
// sdf_bf_stage
// Radix-2 single-path delay-feedback (DIF) butterfly stage, trivial twiddles.
// Feeds the bit-reversal reorder stage directly.
//
// Every block of 2*DELAY accepted samples is split into two halves:
//   phase 0 : the input is parked in the delay line; the slot's old content
//             (a difference left over from the previous block) is emitted.
//   phase 1 : a = parked word, b = input; a+b is emitted and a-b is parked
//             in the same slot, to leave during the next block's phase 0.
//
// Ports
//   mclk   : clock, all state changes on its rising edge
//   i_rst  : asynchronous active-high reset
//   i_init : synchronous restart, same effect as i_rst at the clock edge
//   bus    : sample stream (sdf_bf_stage_if.slave), results registered one
//            clock after the accepting cycle
// ----------------------------------------------------------------------------
module sdf_bf_stage #(
    parameter int DATA_W = 16,
    parameter int DELAY  = 64
) (
    input  logic            mclk,
    input  logic            i_rst,
    input  logic            i_init,
    sdf_bf_stage_if.slave   bus
);

    localparam int W      = DATA_W + 1;
    localparam int CNT_W  = $clog2(DELAY) + 1;
    localparam int ADDR_W = (DELAY > 1) ? $clog2(DELAY) : 1;

    // Sample counter; its MSB is the phase. 2*DELAY is a power of two, so
    // the natural wrap of the counter is the block boundary.
    logic [CNT_W-1:0]  cnt_reg;
    logic [CNT_W-1:0]  cnt_next;
    logic              primed_reg;
    logic              phase;
    logic [ADDR_W-1:0] addr;
    logic              last_of_half;
    logic              accept;

    // Delay line. No reset: stale contents are kept off the output by the
    // primed flag. Read is asynchronous so that the add/subtract and the
    // write-back happen in the same cycle the sample is accepted.
    logic signed [W-1:0] line_re [DELAY];
    logic signed [W-1:0] line_im [DELAY];

    logic signed [W-1:0] a_re, a_im;
    logic signed [W-1:0] b_re, b_im;
    logic signed [W-1:0] sum_re, sum_im;
    logic signed [W-1:0] diff_re, diff_im;

    logic                emit;
    logic signed [W-1:0] res_re, res_im;
    logic                res_sum;
    logic signed [W-1:0] wr_re, wr_im;

    logic                out_vld_reg;
    logic signed [W-1:0] out_re_reg, out_im_reg;
    logic                out_sum_reg;

    assign phase = cnt_reg[CNT_W-1];

    generate
        if (DELAY > 1) begin : g_addr
            assign addr = cnt_reg[ADDR_W-1:0];
        end else begin : g_addr_single
            // The delay line is a single register; there is nothing to index.
            assign addr = '0;
        end
    endgenerate

    assign last_of_half = (addr == ADDR_W'(DELAY - 1));
    assign accept       = bus.i_vld && !i_init;
    assign cnt_next     = cnt_reg + CNT_W'(1);

    assign a_re = line_re[addr];
    assign a_im = line_im[addr];
    assign b_re = {bus.i_re[DATA_W-1], bus.i_re};
    assign b_im = {bus.i_im[DATA_W-1], bus.i_im};

    // Both operands are DATA_W+1 wide, so the results are exact.
    assign sum_re  = a_re + b_re;
    assign sum_im  = a_im + b_im;
    assign diff_re = a_re - b_re;
    assign diff_im = a_im - b_im;

    always_comb begin
        emit    = primed_reg;
        res_re  = a_re;
        res_im  = a_im;
        res_sum = 1'b0;
        wr_re   = b_re;
        wr_im   = b_im;
        if (phase) begin
            emit    = 1'b1;
            res_re  = sum_re;
            res_im  = sum_im;
            res_sum = 1'b1;
            wr_re   = diff_re;
            wr_im   = diff_im;
        end
    end

    always_ff @(posedge mclk or posedge i_rst) begin
        if (i_rst) begin
            cnt_reg     <= '0;
            primed_reg  <= 1'b0;
            out_vld_reg <= 1'b0;
            out_re_reg  <= '0;
            out_im_reg  <= '0;
            out_sum_reg <= 1'b0;
        end else if (i_init) begin
            // Restart wins over a simultaneous sample, which is dropped.
            cnt_reg     <= '0;
            primed_reg  <= 1'b0;
            out_vld_reg <= 1'b0;
            out_re_reg  <= '0;
            out_im_reg  <= '0;
            out_sum_reg <= 1'b0;
        end else if (bus.i_vld) begin
            cnt_reg     <= cnt_next;
            out_vld_reg <= emit;
            // The first phase-0 half only fills the line; from then on every
            // slot holds a real difference.
            if (!phase && last_of_half) begin
                primed_reg <= 1'b1;
            end
            // Suppressed outputs leave the data registers untouched so that
            // uninitialised delay-line words never appear on the bus.
            if (emit) begin
                out_re_reg  <= res_re;
                out_im_reg  <= res_im;
                out_sum_reg <= res_sum;
            end
        end else begin
            out_vld_reg <= 1'b0;
        end
    end

    always_ff @(posedge mclk) begin
        if (accept) begin
            line_re[addr] <= wr_re;
            line_im[addr] <= wr_im;
        end
    end

    assign bus.o_vld = out_vld_reg;
    assign bus.o_re  = out_re_reg;
    assign bus.o_im  = out_im_reg;
    assign bus.o_sum = out_sum_reg;

endmodule
